rob_commit_ctrl: RTL and testbench
==================================

# rob_commit_ctrl

Retirement sequencer for the reorder buffer queue. Each cycle it scans the oldest COMMIT_WIDTH ROB entries and retires the longest in-order prefix that is eligible, driving the dequeue count, RRAT updates and the single store-commit port. When it reaches an exception, interrupt or trap it retires the older entries, issues a one-cycle flush to the ROB and frontend, then holds a PC redirect until fetch acknowledges it.

## Interface
- COMMIT_WIDTH, default uop_pkg::INSTR_Q_WIDTH: number of head slots examined per cycle.
- ROB_DEPTH, default rob_pkg::ROB_ENTRIES: ROB capacity.
- ADDR_BITS, default 64: PC width.
- clk_in  in  1  clock.
- rst_in  in  1  reset, synchronous, active-high.
- head_in  in  rob_entry[COMMIT_WIDTH]  oldest entries; slot 0 is the ROB head.
- rob_size_in  in  $clog2(ROB_DEPTH+1)  ROB occupancy.
- st_ready_in  in  1  store buffer can accept a store this cycle.
- redirect_ack_in  in  1  fetch accepted the redirect.
- deq_out  out  $clog2(COMMIT_WIDTH+1)  entries retired this cycle.
- rrat_we_out  out  COMMIT_WIDTH  per-slot RRAT write enable.
- rrat_arch_out  out  [COMMIT_WIDTH][$clog2(NUM_ARCH_REGS)]  arch dst per slot.
- rrat_phys_out  out  [COMMIT_WIDTH][$clog2(NUM_PHYS_REGS)]  phys dst per slot.
- str_valid_out  out  1  store committed this cycle.
- str_addr_reg_out, str_off_reg_out, str_val_reg_out  out  $clog2(NUM_ARCH_REGS) each  registers of the committed store: dst, src2 and src1 respectively.
- flush_out  out  1  flush ROB and frontend.
- valid_pc_out  out  1  redirect valid.
- pc_out  out  ADDR_BITS  redirect target.
- epc_out  out  ADDR_BITS  PC of the faulting entry.
- cause_out  out  rob_status  status of the faulting entry.

## Operation
- FSM states: RUN, FLUSH, REDIRECT. Reset state is RUN.
- **RUN.** Slot i is retired when all of the following hold:
  - i < rob_size_in;
  - slots 0..i-1 are retired;
  - its status is DONE;
  - if it is a UOP_STORE: st_ready_in=1 and no earlier store was retired this cycle.
- **Scan stop.** The scan stops at the first slot that fails these conditions.
- **Per retired slot.** rrat_we_out[i] = dst_valid, with the arch and phys dst driven alongside. A retired store drives the str_* outputs.
- **Fault detection.** If the first non-retired slot has i < rob_size_in and status EXCEPTION, INTERRUPT or TRAP:
  - the faulting entry is not retired;
  - epc_out, cause_out and the target are latched;
  - next state is FLUSH.
- **Redirect targets.** EXCEPTION → EXC_VECTOR, INTERRUPT → IRQ_VECTOR, TRAP → TRAP_VECTOR.
- **FLUSH.** flush_out=1 for exactly one cycle, deq_out=0, next state REDIRECT.
- **REDIRECT.**
  - valid_pc_out=1 and pc_out=latched target, held stable until redirect_ack_in=1.
  - Leaves for RUN in the cycle after an ack is sampled.
  - An ack arriving in the first REDIRECT cycle is legal.
- **Commit outputs outside RUN.** In FLUSH and REDIRECT all commit outputs are 0 and head_in is ignored.
- **rob_size_in = 0.** Nothing is retired and no fault is detected, regardless of head_in contents.
- **Non-terminal statuses.** Any status other than DONE/EXCEPTION/INTERRUPT/TRAP (e.g. issued or pending) blocks the scan without faulting.

## Timing
- **Combinational commit outputs.** deq_out, rrat_*, str_* are combinational from head_in, rob_size_in, st_ready_in and state. The ROB samples deq_out at the same clock edge: zero-cycle commit latency.
- **Registered outputs.** flush_out, valid_pc_out, pc_out, epc_out, cause_out are decoded from registered state. flush_out rises the cycle after the faulting head is seen.
- **Fault-to-redirect latency.** Fault cycle → FLUSH (+1) → REDIRECT (+2) → RUN at the earliest at +3.
- **Reset.**
  - While rst_in=1, every output is 0, including the combinational ones.
  - epc_out, pc_out and cause_out reset to 0.
  - Reset dominates all other events; reset in FLUSH or REDIRECT drops flush_out and valid_pc_out on the next cycle.
- **Simultaneous DONE and fault.** DONE slots older than the fault retire in the same cycle the fault is detected.

## Configuration
- **ROB_COMMIT_PERF_EN defined:**
  - adds retired_cnt_out (64 bits), which accumulates deq_out every cycle;
  - adds flush_cnt_out (32 bits), which increments on each FLUSH entry;
  - both counters clear on rst_in and wrap on overflow.
- **ROB_COMMIT_PERF_EN undefined:** the ports and counters are absent and behaviour is otherwise identical.

## Structure
- **rob_pkg holds:**
  - the commit_state_e enum;
  - EXC_VECTOR, IRQ_VECTOR, TRAP_VECTOR as ADDR_BITS constants;
  - rob_entry with fields status, uop, pc, dst_valid, arch_dst, phys_dst.
- **Sub-module rob_commit_select:** a purely combinational prefix scan producing the retire mask, deq count, store slot and first-fault index. rob_commit_ctrl holds the FSM, latches and counters.

## Test plan
All scenarios use COMMIT_WIDTH=4.
1. **Reset.** rst_in=1 for 2 cycles with 4 DONE entries and size 8 → deq_out=0, flush_out=0, valid_pc_out=0; after release, deq_out=4.
2. **Full-width retire.** 4 DONE ALU uops, dst_valid=1, arch 1..4, phys 10..13, size 4 → deq_out=4, rrat_we_out=4'b1111, rrat_phys_out={13,12,11,10}.
3. **Blocked slot and size cap.**
   - Statuses DONE, DONE, pending, DONE → deq_out=2, rrat_we_out=4'b0011.
   - 4 DONE with size 1 → deq_out=1.
4. **Store rules.**
   - DONE stores in slots 0 and 1, st_ready_in=1 → deq_out=1, str_valid_out=1, slot 0 registers driven.
   - Same stimulus with st_ready_in=0 → deq_out=0, str_valid_out=0.
5. **Exception with delayed ack.** Slot 0 DONE, slot 1 EXCEPTION at pc 0x1000 →
   - fault cycle: deq_out=1;
   - next cycle: flush_out=1 for one cycle;
   - then valid_pc_out=1 with pc_out=EXC_VECTOR, epc_out=0x1000, cause_out=EXCEPTION, held for 3 cycles with ack low;
   - ack → RUN the next cycle.
6. **Immediate ack, then reset mid-redirect.**
   - TRAP at slot 0 with ack held high → redirect lasts exactly 1 cycle, pc_out=TRAP_VECTOR.
   - Repeat with rst_in asserted during REDIRECT → valid_pc_out=0 on the next cycle.

Source files
------------

// File: rtl/rob_commit_ctrl_pkg.sv
// Shared retirement types: uop kinds, ROB entry layout, commit FSM states and redirect vectors.
// Pure declarations; no latency or backpressure of its own.
package uop_pkg;
  localparam int INSTR_Q_WIDTH = 4;

  typedef enum logic [1:0] {
    UOP_ALU    = 2'd0,
    UOP_LOAD   = 2'd1,
    UOP_STORE  = 2'd2,
    UOP_BRANCH = 2'd3
  } uop_type_e;
endpackage

package rob_pkg;
  import uop_pkg::*;

  localparam int ROB_ENTRIES   = 16;
  localparam int NUM_ARCH_REGS = 32;
  localparam int NUM_PHYS_REGS = 64;
  localparam int PC_BITS       = 64;
  localparam int ARCH_W        = $clog2(NUM_ARCH_REGS);
  localparam int PHYS_W        = $clog2(NUM_PHYS_REGS);

  localparam logic [PC_BITS-1:0] EXC_VECTOR  = 64'h0000_0000_0000_0100;
  localparam logic [PC_BITS-1:0] IRQ_VECTOR  = 64'h0000_0000_0000_0200;
  localparam logic [PC_BITS-1:0] TRAP_VECTOR = 64'h0000_0000_0000_0300;

  typedef enum logic [2:0] {
    ST_ISSUED    = 3'd0,
    ST_PENDING   = 3'd1,
    ST_DONE      = 3'd2,
    ST_EXCEPTION = 3'd3,
    ST_INTERRUPT = 3'd4,
    ST_TRAP      = 3'd5
  } rob_status;

  typedef enum logic [1:0] {
    S_RUN      = 2'd0,
    S_FLUSH    = 2'd1,
    S_REDIRECT = 2'd2
  } commit_state_e;

  // src1/src2 carry the store value and offset registers to the store-commit port.
  typedef struct packed {
    rob_status         status;
    uop_type_e         uop;
    logic [PC_BITS-1:0] pc;
    logic              dst_valid;
    logic [ARCH_W-1:0] arch_dst;
    logic [PHYS_W-1:0] phys_dst;
    logic [ARCH_W-1:0] src1;
    logic [ARCH_W-1:0] src2;
  } rob_entry;

  function automatic logic is_fault(rob_status s);
    return (s == ST_EXCEPTION) || (s == ST_INTERRUPT) || (s == ST_TRAP);
  endfunction
endpackage

// File: rtl/rob_commit_ctrl_select.sv
// Combinational in-order prefix scan over the ROB head: retire mask, count, store slot, first fault.
// Zero latency; a store without st_ready_i (or a second store) ends the prefix.
module rob_commit_select
  import uop_pkg::*;
  import rob_pkg::*;
#(
  parameter int COMMIT_WIDTH = INSTR_Q_WIDTH,
  parameter int ROB_DEPTH    = ROB_ENTRIES,
  localparam int SIZE_W      = $clog2(ROB_DEPTH + 1),
  localparam int DEQ_W       = $clog2(COMMIT_WIDTH + 1),
  localparam int IDX_W       = (COMMIT_WIDTH > 1) ? $clog2(COMMIT_WIDTH) : 1
) (
  input  rob_status [COMMIT_WIDTH-1:0] status_i,
  input  logic [COMMIT_WIDTH-1:0]      store_i,
  input  logic [SIZE_W-1:0]            rob_size_i,
  input  logic                         st_ready_i,
  output logic [COMMIT_WIDTH-1:0]      retire_o,
  output logic [DEQ_W-1:0]             deq_o,
  output logic                         st_vld_o,
  output logic [IDX_W-1:0]             st_idx_o,
  output logic                         fault_vld_o,
  output logic [IDX_W-1:0]             fault_idx_o
);
  logic stop;

  always_comb begin
    retire_o    = '0;
    deq_o       = '0;
    st_vld_o    = 1'b0;
    st_idx_o    = '0;
    fault_vld_o = 1'b0;
    fault_idx_o = '0;
    stop        = 1'b0;
    for (int i = 0; i < COMMIT_WIDTH; i++) begin
      if (!stop) begin
        if (i >= int'(rob_size_i)) begin
          stop = 1'b1;
        end else if (status_i[i] == ST_DONE && !(store_i[i] && (!st_ready_i || st_vld_o))) begin
          retire_o[i] = 1'b1;
          deq_o       = deq_o + DEQ_W'(1);
          if (store_i[i]) begin
            st_vld_o = 1'b1;
            st_idx_o = IDX_W'(i);
          end
        end else begin
          // Only a terminal fault status raises a fault; pending entries just stall.
          stop = 1'b1;
          if (is_fault(status_i[i])) begin
            fault_vld_o = 1'b1;
            fault_idx_o = IDX_W'(i);
          end
        end
      end
    end
  end
endmodule

// File: rtl/rob_commit_ctrl.sv
// ROB retirement sequencer: zero-cycle commit, then FLUSH (1 cycle) and REDIRECT held until fetch acks.
// Backpressure: store port via st_ready_in, redirect via redirect_ack_in; ROB_COMMIT_PERF_EN adds counters.
module rob_commit_ctrl
  import uop_pkg::*;
  import rob_pkg::*;
#(
  parameter int COMMIT_WIDTH = INSTR_Q_WIDTH,
  parameter int ROB_DEPTH    = ROB_ENTRIES,
  parameter int ADDR_BITS    = 64,
  localparam int SIZE_W      = $clog2(ROB_DEPTH + 1),
  localparam int DEQ_W       = $clog2(COMMIT_WIDTH + 1),
  localparam int IDX_W       = (COMMIT_WIDTH > 1) ? $clog2(COMMIT_WIDTH) : 1
) (
  input  logic                                 clk_in,
  input  logic                                 rst_in,
  input  rob_entry [COMMIT_WIDTH-1:0]          head_in,
  input  logic [SIZE_W-1:0]                    rob_size_in,
  input  logic                                 st_ready_in,
  input  logic                                 redirect_ack_in,
  output logic [DEQ_W-1:0]                     deq_out,
  output logic [COMMIT_WIDTH-1:0]              rrat_we_out,
  output logic [COMMIT_WIDTH-1:0][ARCH_W-1:0]  rrat_arch_out,
  output logic [COMMIT_WIDTH-1:0][PHYS_W-1:0]  rrat_phys_out,
  output logic                                 str_valid_out,
  output logic [ARCH_W-1:0]                    str_addr_reg_out,
  output logic [ARCH_W-1:0]                    str_off_reg_out,
  output logic [ARCH_W-1:0]                    str_val_reg_out,
  output logic                                 flush_out,
  output logic                                 valid_pc_out,
  output logic [ADDR_BITS-1:0]                 pc_out,
  output logic [ADDR_BITS-1:0]                 epc_out,
  output rob_status                            cause_out
`ifdef ROB_COMMIT_PERF_EN
  ,
  output logic [63:0]                          retired_cnt_out,
  output logic [31:0]                          flush_cnt_out
`endif
);
  commit_state_e        state_q, state_d;
  logic [ADDR_BITS-1:0] target_q, epc_q;
  rob_status            cause_q;

  rob_status [COMMIT_WIDTH-1:0] status;
  logic [COMMIT_WIDTH-1:0]      store;
  logic [COMMIT_WIDTH-1:0]      sel_retire;
  logic [DEQ_W-1:0]             sel_deq;
  logic                         sel_st_vld, sel_fault_vld;
  logic [IDX_W-1:0]             sel_st_idx, sel_fault_idx;
  logic                         run;
  rob_entry                     fault_entry;

  always_comb begin
    for (int i = 0; i < COMMIT_WIDTH; i++) begin
      status[i] = head_in[i].status;
      store[i]  = (head_in[i].uop == UOP_STORE);
    end
  end

  rob_commit_select #(
    .COMMIT_WIDTH(COMMIT_WIDTH),
    .ROB_DEPTH   (ROB_DEPTH)
  ) u_select (
    .status_i   (status),
    .store_i    (store),
    .rob_size_i (rob_size_in),
    .st_ready_i (st_ready_in),
    .retire_o   (sel_retire),
    .deq_o      (sel_deq),
    .st_vld_o   (sel_st_vld),
    .st_idx_o   (sel_st_idx),
    .fault_vld_o(sel_fault_vld),
    .fault_idx_o(sel_fault_idx)
  );

  assign run         = (state_q == S_RUN) && !rst_in;
  assign fault_entry = head_in[sel_fault_idx];

  always_comb begin
    deq_out          = '0;
    rrat_we_out      = '0;
    rrat_arch_out    = '0;
    rrat_phys_out    = '0;
    str_valid_out    = 1'b0;
    str_addr_reg_out = '0;
    str_off_reg_out  = '0;
    str_val_reg_out  = '0;
    if (run) begin
      deq_out = sel_deq;
      for (int i = 0; i < COMMIT_WIDTH; i++) begin
        if (sel_retire[i]) begin
          rrat_we_out[i]   = head_in[i].dst_valid;
          rrat_arch_out[i] = head_in[i].arch_dst;
          rrat_phys_out[i] = head_in[i].phys_dst;
        end
      end
      if (sel_st_vld) begin
        str_valid_out    = 1'b1;
        str_addr_reg_out = head_in[sel_st_idx].arch_dst;
        str_off_reg_out  = head_in[sel_st_idx].src2;
        str_val_reg_out  = head_in[sel_st_idx].src1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RUN:      if (sel_fault_vld) state_d = S_FLUSH;
      S_FLUSH:    state_d = S_REDIRECT;
      S_REDIRECT: if (redirect_ack_in) state_d = S_RUN;
      default:    state_d = S_RUN;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q  <= S_RUN;
      target_q <= '0;
      epc_q    <= '0;
      cause_q  <= ST_ISSUED;
    end else begin
      state_q <= state_d;
      if (state_q == S_RUN && sel_fault_vld) begin
        epc_q   <= ADDR_BITS'(fault_entry.pc);
        cause_q <= fault_entry.status;
        case (fault_entry.status)
          ST_EXCEPTION: target_q <= ADDR_BITS'(EXC_VECTOR);
          ST_INTERRUPT: target_q <= ADDR_BITS'(IRQ_VECTOR);
          default:      target_q <= ADDR_BITS'(TRAP_VECTOR);
        endcase
      end
    end
  end

  // Reset forces every output low, including the registered decodes.
  assign flush_out    = !rst_in && (state_q == S_FLUSH);
  assign valid_pc_out = !rst_in && (state_q == S_REDIRECT);
  assign pc_out       = rst_in ? '0 : target_q;
  assign epc_out      = rst_in ? '0 : epc_q;
  assign cause_out    = rst_in ? ST_ISSUED : cause_q;

`ifdef ROB_COMMIT_PERF_EN
  logic [63:0] retired_cnt_q;
  logic [31:0] flush_cnt_q;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      retired_cnt_q <= '0;
      flush_cnt_q   <= '0;
    end else begin
      retired_cnt_q <= retired_cnt_q + 64'(deq_out);
      if (state_q == S_RUN && state_d == S_FLUSH) flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end

  assign retired_cnt_out = rst_in ? '0 : retired_cnt_q;
  assign flush_cnt_out   = rst_in ? '0 : flush_cnt_q;
`endif
endmodule

// File: tb/tb_rob_commit_ctrl.sv
// Directed bench for rob_commit_ctrl with COMMIT_WIDTH=4: retire rules, store port, fault/flush/redirect, reset.
module tb_rob_commit_ctrl;
  import uop_pkg::*;
  import rob_pkg::*;

  logic                clk_in = 1'b0;
  logic                rst_in;
  rob_entry [3:0]      head_in;
  logic [4:0]          rob_size_in;
  logic                st_ready_in;
  logic                redirect_ack_in;
  logic [2:0]          deq_out;
  logic [3:0]          rrat_we_out;
  logic [3:0][4:0]     rrat_arch_out;
  logic [3:0][5:0]     rrat_phys_out;
  logic                str_valid_out;
  logic [4:0]          str_addr_reg_out, str_off_reg_out, str_val_reg_out;
  logic                flush_out, valid_pc_out;
  logic [63:0]         pc_out, epc_out;
  rob_status           cause_out;

  int checks   = 0;
  int failures = 0;

  rob_commit_ctrl #(.COMMIT_WIDTH(4), .ROB_DEPTH(16), .ADDR_BITS(64)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .head_in(head_in), .rob_size_in(rob_size_in),
    .st_ready_in(st_ready_in), .redirect_ack_in(redirect_ack_in),
    .deq_out(deq_out), .rrat_we_out(rrat_we_out), .rrat_arch_out(rrat_arch_out),
    .rrat_phys_out(rrat_phys_out), .str_valid_out(str_valid_out),
    .str_addr_reg_out(str_addr_reg_out), .str_off_reg_out(str_off_reg_out),
    .str_val_reg_out(str_val_reg_out), .flush_out(flush_out), .valid_pc_out(valid_pc_out),
    .pc_out(pc_out), .epc_out(epc_out), .cause_out(cause_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  function automatic rob_entry mk(rob_status st, uop_type_e u, logic [63:0] pc,
                                  logic dv, logic [4:0] a, logic [5:0] p,
                                  logic [4:0] s1, logic [4:0] s2);
    rob_entry e;
    e.status = st; e.uop = u; e.pc = pc; e.dst_valid = dv;
    e.arch_dst = a; e.phys_dst = p; e.src1 = s1; e.src2 = s2;
    return e;
  endfunction

  task automatic all_done();
    for (int i = 0; i < 4; i++)
      head_in[i] = mk(ST_DONE, UOP_ALU, 64'h100 + 64'(4 * i), 1'b1, 5'(i + 1), 6'(i + 10), 5'd0, 5'd0);
  endtask

  initial begin
    // 1: reset with 4 DONE entries and size 8
    rst_in = 1'b1; st_ready_in = 1'b1; redirect_ack_in = 1'b0; rob_size_in = 5'd8;
    all_done();
    #1;
    chk("rst_deq_comb", 64'(deq_out), 64'd0);
    tick();
    chk("rst_deq_c1", 64'(deq_out), 64'd0);
    chk("rst_flush_c1", 64'(flush_out), 64'd0);
    chk("rst_vpc_c1", 64'(valid_pc_out), 64'd0);
    tick();
    chk("rst_deq_c2", 64'(deq_out), 64'd0);
    chk("rst_epc", epc_out, 64'd0);
    chk("rst_pc", pc_out, 64'd0);
    rst_in = 1'b0;
    #1;
    chk("post_rst_deq", 64'(deq_out), 64'd4);

    // 2: full-width retire
    rob_size_in = 5'd4;
    #1;
    chk("full_deq", 64'(deq_out), 64'd4);
    chk("full_we", 64'(rrat_we_out), 64'b1111);
    chk("full_phys", 64'(rrat_phys_out), 64'({6'd13, 6'd12, 6'd11, 6'd10}));
    chk("full_arch", 64'(rrat_arch_out), 64'({5'd4, 5'd3, 5'd2, 5'd1}));
    chk("full_str", 64'(str_valid_out), 64'd0);

    // 3: blocked slot, size cap, empty ROB
    head_in[2].status = ST_PENDING;
    #1;
    chk("blk_deq", 64'(deq_out), 64'd2);
    chk("blk_we", 64'(rrat_we_out), 64'b0011);
    all_done();
    rob_size_in = 5'd1;
    #1;
    chk("cap_deq", 64'(deq_out), 64'd1);
    chk("cap_we", 64'(rrat_we_out), 64'b0001);
    head_in[0].status = ST_EXCEPTION;
    rob_size_in = 5'd0;
    #1;
    chk("empty_deq", 64'(deq_out), 64'd0);
    tick();
    chk("empty_noflush", 64'(flush_out), 64'd0);

    // 4: store rules
    all_done();
    rob_size_in = 5'd4;
    head_in[0] = mk(ST_DONE, UOP_STORE, 64'h200, 1'b0, 5'd7, 6'd0, 5'd5, 5'd6);
    head_in[1] = mk(ST_DONE, UOP_STORE, 64'h204, 1'b0, 5'd9, 6'd0, 5'd3, 5'd2);
    #1;
    chk("st_deq", 64'(deq_out), 64'd1);
    chk("st_vld", 64'(str_valid_out), 64'd1);
    chk("st_addr", 64'(str_addr_reg_out), 64'd7);
    chk("st_off", 64'(str_off_reg_out), 64'd6);
    chk("st_val", 64'(str_val_reg_out), 64'd5);
    chk("st_we", 64'(rrat_we_out), 64'd0);
    st_ready_in = 1'b0;
    #1;
    chk("st_nrdy_deq", 64'(deq_out), 64'd0);
    chk("st_nrdy_vld", 64'(str_valid_out), 64'd0);
    st_ready_in = 1'b1;

    // 5: exception at slot 1, ack delayed
    all_done();
    head_in[1] = mk(ST_EXCEPTION, UOP_ALU, 64'h1000, 1'b1, 5'd2, 6'd11, 5'd0, 5'd0);
    #1;
    chk("exc_deq", 64'(deq_out), 64'd1);
    chk("exc_noflush", 64'(flush_out), 64'd0);
    tick();
    chk("exc_flush", 64'(flush_out), 64'd1);
    chk("exc_flush_deq", 64'(deq_out), 64'd0);
    chk("exc_flush_vpc", 64'(valid_pc_out), 64'd0);
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("exc_rd_vpc", 64'(valid_pc_out), 64'd1);
      chk("exc_rd_flush", 64'(flush_out), 64'd0);
      chk("exc_rd_pc", pc_out, 64'h100);
      chk("exc_rd_deq", 64'(deq_out), 64'd0);
    end
    chk("exc_epc", epc_out, 64'h1000);
    chk("exc_cause", 64'(cause_out), 64'(ST_EXCEPTION));
    redirect_ack_in = 1'b1;
    tick();
    redirect_ack_in = 1'b0;
    all_done();
    #1;
    chk("exc_back_vpc", 64'(valid_pc_out), 64'd0);
    chk("exc_back_deq", 64'(deq_out), 64'd4);

    // interrupt at slot 2 behind two DONE entries
    head_in[2] = mk(ST_INTERRUPT, UOP_ALU, 64'h3000, 1'b1, 5'd3, 6'd12, 5'd0, 5'd0);
    #1;
    chk("irq_deq", 64'(deq_out), 64'd2);
    tick();
    tick();
    chk("irq_pc", pc_out, 64'h200);
    chk("irq_epc", epc_out, 64'h3000);
    chk("irq_cause", 64'(cause_out), 64'(ST_INTERRUPT));
    redirect_ack_in = 1'b1;
    all_done();
    tick();
    redirect_ack_in = 1'b0;
    chk("irq_back_vpc", 64'(valid_pc_out), 64'd0);

    // 6a: trap at slot 0 with ack already high
    head_in[0] = mk(ST_TRAP, UOP_ALU, 64'h2000, 1'b1, 5'd1, 6'd10, 5'd0, 5'd0);
    redirect_ack_in = 1'b1;
    #1;
    chk("trap_deq", 64'(deq_out), 64'd0);
    tick();
    chk("trap_flush", 64'(flush_out), 64'd1);
    tick();
    chk("trap_vpc", 64'(valid_pc_out), 64'd1);
    chk("trap_pc", pc_out, 64'h300);
    chk("trap_cause", 64'(cause_out), 64'(ST_TRAP));
    chk("trap_epc", epc_out, 64'h2000);
    all_done();
    tick();
    chk("trap_1cyc_vpc", 64'(valid_pc_out), 64'd0);
    chk("trap_back_deq", 64'(deq_out), 64'd4);

    // 6b: reset during REDIRECT
    redirect_ack_in = 1'b0;
    head_in[0] = mk(ST_TRAP, UOP_ALU, 64'h2400, 1'b1, 5'd1, 6'd10, 5'd0, 5'd0);
    tick();
    chk("rr_flush", 64'(flush_out), 64'd1);
    tick();
    chk("rr_vpc", 64'(valid_pc_out), 64'd1);
    rst_in = 1'b1;
    tick();
    chk("rr_vpc_drop", 64'(valid_pc_out), 64'd0);
    chk("rr_flush_drop", 64'(flush_out), 64'd0);
    chk("rr_pc", pc_out, 64'd0);
    chk("rr_epc", epc_out, 64'd0);
    chk("rr_cause", 64'(cause_out), 64'd0);
    chk("rr_deq", 64'(deq_out), 64'd0);
    rst_in = 1'b0;
    all_done();
    tick();
    chk("rr_back_vpc", 64'(valid_pc_out), 64'd0);
    chk("rr_back_deq", 64'(deq_out), 64'd4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
